mux_rr_arb: RTL
===============

# mux_rr_arb

Parametrised N-channel, W-bit registered multiplexer with a valid/ready handshake on every input and on the output. It picks the source either from a fixed `sel` input or by round-robin arbitration, and registers the chosen beat into a one-entry output stage. It sits between several producer channels and one consumer, and replaces plain combinational key/default selectors wherever flow control or fair sharing is needed.

## Interface
- `NR_CH`, 4: number of input channels, ≥2
- `DATA_LEN`, 1: data width per channel, ≥1
- `SEL_LEN`, `$clog2(NR_CH)`: width of `sel` and `out_ch`; derived, not overridden
- `clk` input 1: single clock, all state on rising edge
- `rst_n` input 1: synchronous, active-low reset
- `mode` input 1: 0 = fixed select by `sel`, 1 = round-robin
- `sel` input SEL_LEN: channel index used in fixed mode
- `in_valid` input NR_CH: per-channel valid
- `in_ready` output NR_CH: per-channel ready, one-hot or zero
- `in_data` input NR_CH*DATA_LEN: channel i at `[i*DATA_LEN +: DATA_LEN]`
- `out_valid` output 1: output register holds a beat
- `out_ready` input 1: consumer accepts
- `out_data` output DATA_LEN: registered beat
- `out_ch` output SEL_LEN: source channel of the registered beat
- `xfer_cnt` output 16: accepted-transfer count; only present with `MUX_RR_ARB_CNT_EN`

## Operation
- Free slot: `can_load = !out_valid || out_ready`.
- Grant is combinational from the registers and the current inputs.
- Fixed mode grant: channel `sel` if `sel < NR_CH` and `in_valid[sel]`. Otherwise there is no grant, and `sel ≥ NR_CH` never grants.
- Round-robin grant: the first `i` with `in_valid[i]`, searching from `ptr` upward modulo NR_CH. If no channel is valid, there is no grant.
- `in_ready[g] = can_load && grant_valid && rst_n`. All other `in_ready` bits are 0.
- Transfer on channel g happens when `in_valid[g] && in_ready[g]`. On that edge:
  - `out_data` takes channel g's data.
  - `out_ch` takes g.
  - `out_valid` goes to 1.
- Round-robin pointer:
  - After a transfer in round-robin mode, `ptr` becomes `(g+1) mod NR_CH`, wrapping from NR_CH-1 to 0.
  - In fixed mode, `ptr` is unchanged.
- Output drain: if `out_valid && out_ready` and there is no new transfer, `out_valid` goes to 0. `out_data` and `out_ch` hold their values.
- Simultaneous drain and load: the new beat replaces the old one and `out_valid` stays 1, giving full throughput.
- `mode` or `sel` changing mid-stream takes effect at the next grant evaluation. A beat already in the output register is never altered.
- Inputs must keep `in_valid` and `in_data` stable until accepted. The block does not check this.

## Timing
- Reset (`rst_n`=0 at an edge): `out_valid`=0, `out_data`=0, `out_ch`=0, `ptr`=0, `xfer_cnt`=0.
- While `rst_n`=0, all `in_ready` are 0.
- Reset asserted mid-operation discards the held beat.
- Latency: an input accepted at edge k appears at `out_valid`/`out_data` after edge k (1 cycle).
- Throughput: 1 beat per cycle while `out_ready`=1.
- Backpressure: when `out_valid`=1 and `out_ready`=0, all `in_ready` are 0 and the output is held stable.
- No combinational path exists from `in_data` to `out_data`.
- A combinational path exists from `out_ready`, `in_valid`, `mode` and `sel` to `in_ready`.

## Configuration
- `MUX_RR_ARB_CNT_EN` defined:
  - Port `xfer_cnt` exists.
  - It increments by 1 on every input transfer and saturates at 16'hFFFF.
  - Reset value is 0.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset then fixed mode: NR_CH=4, DATA_LEN=8, `mode`=0, `sel`=2, all `in_valid`=1, data i=8'hA0+i, `out_ready`=1.
  - Required: only `in_ready[2]`=1.
  - Required: from cycle 1, `out_data`=8'hA2 and `out_ch`=2 on every cycle.
- Round-robin with all channels valid, `out_ready`=1.
  - Required: `out_ch` sequence 0,1,2,3,0,1, one beat per cycle.
- Round-robin skip and wrap: only channels 1 and 3 valid, `ptr` starting at 0.
  - Required: grants 1,3,1,3.
  - Required: when channel 3 alone becomes valid right after a grant to 3, it wins again (search wraps from `ptr`=0).
- Backpressure: `out_ready`=0 for 3 cycles after the first beat.
  - Required: `in_ready`=0 for those 3 cycles and `out_data` stable.
  - Required: on release, the held beat drains and the next beat loads in the same cycle.
- Fixed mode with `sel`=2 and `in_valid`=4'b1011.
  - Required: no `in_ready`, `out_valid` falls after drain.
  - Then `sel`=5 with NR_CH=8 and channel 5 invalid: still no grant.
- Reset mid-stream with `out_valid`=1: assert `rst_n`=0 for one edge.
  - Required: `out_valid`=0 and `ptr`=0 next cycle.
  - With `MUX_RR_ARB_CNT_EN`: `xfer_cnt`=0, and it reaches 5 after 5 transfers.

Source files
------------

// File: rtl/mux_rr_arb.sv
// mux_rr_arb: N-channel registered multiplexer with valid/ready handshakes.
// The source is picked either by a fixed `sel` index or by round-robin
// arbitration, and the chosen beat lands in a one-entry output register
// that supports simultaneous drain and load for full throughput.
// Optional feature: define MUX_RR_ARB_CNT_EN to add the saturating 16-bit
// accepted-transfer counter on port `xfer_cnt`.
module mux_rr_arb #(
   parameter  int unsigned NR_CH    = 4,
   parameter  int unsigned DATA_LEN = 1,
   localparam int unsigned SEL_LEN  = $clog2(NR_CH)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mode,
   input  logic [SEL_LEN-1:0]        sel,
   input  logic [NR_CH-1:0]          in_valid,
   output logic [NR_CH-1:0]          in_ready,
   input  logic [NR_CH*DATA_LEN-1:0] in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_LEN-1:0]       out_data,
   output logic [SEL_LEN-1:0]        out_ch
`ifdef MUX_RR_ARB_CNT_EN
   ,
   output logic [15:0]               xfer_cnt
`endif
);

   logic [SEL_LEN-1:0] ptr;
   logic [SEL_LEN-1:0] grant;
   logic               grant_valid;
   logic               can_load;
   logic               load;
   logic [SEL_LEN-1:0] ptr_next;

   assign can_load = !out_valid || out_ready;
   assign load     = can_load && grant_valid && rst_n;

   // Grant selection: fixed index in mode 0, rotating search from ptr in mode 1.
   // An out-of-range sel simply matches no loop index and therefore never grants.
   always_comb begin
      int unsigned        idx;
      logic [SEL_LEN-1:0] idx_s;
      grant       = '0;
      grant_valid = 1'b0;
      idx         = 0;
      idx_s       = '0;
      if (!mode) begin
         for (int unsigned i = 0; i < NR_CH; i++) begin
            if (sel == SEL_LEN'(i) && in_valid[i]) begin
               grant       = SEL_LEN'(i);
               grant_valid = 1'b1;
            end
         end
      end else begin
         for (int unsigned k = 0; k < NR_CH; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NR_CH) begin
               idx = idx - NR_CH;
            end
            idx_s = idx[SEL_LEN-1:0];
            if (!grant_valid && in_valid[idx_s]) begin
               grant       = idx_s;
               grant_valid = 1'b1;
            end
         end
      end
   end

   // One-hot ready toward the granted channel only when the output slot is free.
   always_comb begin
      in_ready = '0;
      if (load) begin
         in_ready[grant] = 1'b1;
      end
   end

   // Pointer successor of the granted channel, wrapping at NR_CH-1.
   always_comb begin
      if (grant == SEL_LEN'(NR_CH - 1)) begin
         ptr_next = '0;
      end else begin
         ptr_next = grant + 1'b1;
      end
   end

   // Output register: load on transfer, clear valid on a drain without reload.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= in_data[grant*DATA_LEN +: DATA_LEN];
         out_ch    <= grant;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Round-robin pointer advances past the winner only in round-robin mode.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (load && mode) begin
         ptr <= ptr_next;
      end
   end

`ifdef MUX_RR_ARB_CNT_EN
   // Saturating count of accepted input transfers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xfer_cnt <= '0;
      end else if (load && xfer_cnt != 16'hFFFF) begin
         xfer_cnt <= xfer_cnt + 16'd1;
      end
   end
`endif

endmodule
